ddr_axi_master: RTL and testbench

- AXI-style initiator that drives the master side of the DDR3 controller port: aw/w/ar/r channels, 256-bit data, 28-bit address.
- Converts simple burst commands from the feature-map and weight memory paths into fixed-length DDR bursts.
- Write data is pulled from a first-word-fall-through (FWFT) source as the controller asserts wready.
- Read data is streamed out as the controller returns it.
- One burst outstanding at a time; commands run sequentially.

---
 rtl/ddr_axi_master.sv | 149 ++++++++++++++
 tb/tb_ddr_axi_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_master.sv
// ddr_axi_master: sequential fixed-length burst initiator for the DDR3 controller AXI port
module ddr_axi_master #(
    parameter int         ADDR_WIDTH      = 28,
    parameter int         DATA_WIDTH      = 256,
    parameter int         BURST_LEN       = 16,
    parameter int         ADDR_STEP       = 128,
    parameter logic [3:0] AXI_ID          = 4'h0,
    parameter int         BURST_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ddr_init_done,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_wr,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic [BURST_CNT_WIDTH-1:0] cmd_burst_num,
    output logic                       busy,
    output logic                       cmd_done,
    output logic                       rd_err,
    output logic                       wr_data_req,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       rd_data_valid,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic [ADDR_WIDTH-1:0]      axi_awaddr,
    output logic [3:0]                 axi_awuser_id,
    output logic [3:0]                 axi_awlen,
    output logic                       axi_awvalid,
    input  logic                       axi_awready,
    output logic [DATA_WIDTH-1:0]      axi_wdata,
    output logic [DATA_WIDTH/8-1:0]    axi_wstrb,
    input  logic                       axi_wready,
    input  logic                       axi_wusero_last,
    output logic [ADDR_WIDTH-1:0]      axi_araddr,
    output logic [3:0]                 axi_aruser_id,
    output logic [3:0]                 axi_arlen,
    output logic                       axi_arvalid,
    input  logic                       axi_arready,
    input  logic [DATA_WIDTH-1:0]      axi_rdata,
    input  logic                       axi_rvalid,
    input  logic                       axi_rlast
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DONE} state_t;
    state_t                     state_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [BURST_CNT_WIDTH-1:0] left_q;
    logic [BW-1:0]              beat_q;
    logic                       busy_q, done_q, err_q, awvalid_q, arvalid_q, rvalid_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic                       cmd_fire, beat_last, beat_fire, burst_end, unused_wlast;
    assign unused_wlast  = axi_wusero_last;
    assign cmd_ready     = !rst && state_q == IDLE && !done_q && ddr_init_done;
    assign cmd_fire      = cmd_valid && cmd_ready;
    assign beat_last     = beat_q == BW'(BURST_LEN - 1);
    assign beat_fire     = (state_q == WR_DATA && axi_wready) || (state_q == RD_DATA && axi_rvalid);
    assign burst_end     = (state_q == WR_DATA) ? beat_last : (axi_rlast || beat_last);
    assign busy          = busy_q;
    assign cmd_done      = done_q;
    assign rd_err        = err_q;
    assign wr_data_req   = state_q == WR_DATA && axi_wready;
    assign axi_wdata     = (state_q == WR_DATA) ? wr_data : '0;
    assign axi_wstrb     = '1;
    assign axi_awaddr    = addr_q;
    assign axi_araddr    = addr_q;
    assign axi_awvalid   = awvalid_q;
    assign axi_arvalid   = arvalid_q;
    assign axi_awlen     = 4'(BURST_LEN - 1);
    assign axi_arlen     = 4'(BURST_LEN - 1);
    assign axi_awuser_id = AXI_ID;
    assign axi_aruser_id = AXI_ID;
    assign rd_data_valid = rvalid_q;
    assign rd_data       = rdata_q;
    // command sequencing: address phase, beat counting, burst stepping and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            left_q    <= '0;
            beat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == RD_DATA && axi_rvalid && axi_rlast != beat_last)
                err_q <= 1'b1;
            case (state_q)
                IDLE: if (cmd_fire) begin
                    addr_q <= cmd_addr;
                    left_q <= cmd_burst_num;
                    err_q  <= 1'b0;
                    busy_q <= 1'b1;
                    if (cmd_burst_num == '0) state_q <= DONE;
                    else if (cmd_wr) begin
                        state_q   <= WR_ADDR;
                        awvalid_q <= 1'b1;
                    end else begin
                        state_q   <= RD_ADDR;
                        arvalid_q <= 1'b1;
                    end
                end
                WR_ADDR: if (axi_awready) begin
                    awvalid_q <= 1'b0;
                    beat_q    <= '0;
                    state_q   <= WR_DATA;
                end
                RD_ADDR: if (axi_arready) begin
                    arvalid_q <= 1'b0;
                    beat_q    <= '0;
                    state_q   <= RD_DATA;
                end
                WR_DATA, RD_DATA: if (beat_fire) begin
                    beat_q <= beat_q + BW'(1);
                    if (burst_end) begin
                        left_q <= left_q - BURST_CNT_WIDTH'(1);
                        addr_q <= addr_q + ADDR_WIDTH'(ADDR_STEP);
                        if (left_q == BURST_CNT_WIDTH'(1)) state_q <= DONE;
                        else if (state_q == WR_DATA) begin
                            state_q   <= WR_ADDR;
                            awvalid_q <= 1'b1;
                        end else begin
                            state_q   <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // read beats forwarded with one cycle of latency, only while a read burst is open
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= state_q == RD_DATA && axi_rvalid;
            rdata_q  <= axi_rdata;
        end
    end
endmodule

// File: tb/tb_ddr_axi_master.sv
// tb_ddr_axi_master: controller/source responder with scoreboard for ddr_axi_master
module tb_ddr_axi_master;
    typedef struct {
        bit          wr;
        logic [27:0] addr;
        int          n;
        int          dly;
        int          wm;
        int          rg;
        int          rl;
        logic [27:0] ef;
        logic [27:0] el;
        int          eb;
        bit          ee;
    } vec_t;

    logic clk = 1'b0;
    logic rst, ddr_init_done, cmd_valid, cmd_wr;
    logic [27:0] cmd_addr;
    logic [7:0] cmd_burst_num;
    logic [255:0] wr_data = '0;
    logic axi_awready = 1'b0, axi_wready = 1'b0, axi_wusero_last = 1'b0, axi_arready = 1'b0;
    logic [255:0] axi_rdata = '0;
    logic axi_rvalid = 1'b0, axi_rlast = 1'b0;
    logic cmd_ready, busy, cmd_done, rd_err, wr_data_req, rd_data_valid;
    logic [255:0] rd_data, axi_wdata;
    logic [27:0] axi_awaddr, axi_araddr;
    logic [3:0] axi_awuser_id, axi_awlen, axi_aruser_id, axi_arlen;
    logic axi_awvalid, axi_arvalid;
    logic [31:0] axi_wstrb;

    int npass = 0, ntotal = 0;
    int aw_dly = 0, wmode = 0, rgap = 0, rlast_at = 15;
    logic [255:0] src_q[$];
    logic [27:0] aw_q[$], ar_q[$];
    int src_idx = 0, w_beats = 0, rd_beats = 0, wdata_err = 0, lat_err = 0, stab_err = 0;
    int done_cnt = 0, valid_cycles = 0, aw_cnt = 0, ar_cnt = 0, r_rem = 0;
    bit req_l = 0, ar_hs = 0, prev_rv = 0, busy_at_done = 0, err_at_done = 0;
    logic [27:0] aw_hold = '0, ar_hold = '0;
    logic [255:0] prev_rd = '0;
    vec_t tab[7];

    ddr_axi_master dut (
        .clk(clk), .rst(rst), .ddr_init_done(ddr_init_done), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_burst_num(cmd_burst_num),
        .busy(busy), .cmd_done(cmd_done), .rd_err(rd_err), .wr_data_req(wr_data_req),
        .wr_data(wr_data), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .axi_awaddr(axi_awaddr), .axi_awuser_id(axi_awuser_id), .axi_awlen(axi_awlen),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wready(axi_wready), .axi_wusero_last(axi_wusero_last),
        .axi_araddr(axi_araddr), .axi_aruser_id(axi_aruser_id), .axi_arlen(axi_arlen),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rdata(axi_rdata),
        .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cmd_done"}, cmd_done, 0);
        chk({tag, "_rd_err"}, rd_err, 0);
        chk({tag, "_wr_data_req"}, wr_data_req, 0);
        chk({tag, "_rd_data_valid"}, rd_data_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_awaddr"}, axi_awaddr, 0);
        chk({tag, "_araddr"}, axi_araddr, 0);
        chk({tag, "_awvalid"}, axi_awvalid, 0);
        chk({tag, "_arvalid"}, axi_arvalid, 0);
        chk({tag, "_wdata"}, axi_wdata, 0);
        chk({tag, "_awlen"}, axi_awlen, 15);
        chk({tag, "_arlen"}, axi_arlen, 15);
        chk({tag, "_awid"}, axi_awuser_id, 0);
        chk({tag, "_arid"}, axi_aruser_id, 0);
        chk({tag, "_wstrb"}, axi_wstrb, 32'hFFFF_FFFF);
    endtask

    task automatic clear_mon();
        aw_q.delete();
        ar_q.delete();
        src_idx = 0;
        w_beats = 0;
        rd_beats = 0;
        wdata_err = 0;
        lat_err = 0;
        stab_err = 0;
        done_cnt = 0;
        valid_cycles = 0;
    endtask

    task automatic run_cmd(input vec_t v, input bit use_tab);
        int nb, bad, t, na, no, beats, obeats;
        bit ee;
        logic [27:0] ea, first, last;
        aw_dly = v.dly;
        wmode = v.wm;
        rgap = v.rg;
        rlast_at = v.rl;
        src_q.delete();
        for (int i = 0; i < 16 * v.n + 4; i++) src_q.push_back(rnd256());
        clear_mon();
        cmd_wr = v.wr;
        cmd_addr = v.addr;
        cmd_burst_num = 8'(v.n);
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        chk("busy_after_accept", busy, 1);
        chk("rd_err_cleared", rd_err, 0);
        chk("cmd_ready_busy", cmd_ready, 0);
        ddr_init_done = 1'b0;
        tick();
        cmd_valid = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            tick();
            t++;
        end
        chk("done_seen", done_cnt != 0, 1);
        chk("busy_at_done", busy_at_done, 0);
        tick();
        tick();
        ddr_init_done = 1'b1;
        nb = v.wr ? 16 * v.n : v.n * (v.rl < 16 ? v.rl + 1 : 16);
        ee = !v.wr && v.n != 0 && v.rl != 15;
        chk("done_once", done_cnt, 1);
        chk("rd_err_sticky", rd_err, ee);
        na = v.wr ? aw_q.size() : ar_q.size();
        no = v.wr ? ar_q.size() : aw_q.size();
        chk("addr_count", na, v.n);
        chk("other_chan", no, 0);
        bad = 0;
        for (int k = 0; k < v.n; k++) begin
            ea = 28'(v.addr + 28'(k * 128));
            if (k >= na) bad++;
            else if ((v.wr ? aw_q[k] : ar_q[k]) !== ea) bad++;
        end
        chk("addr_seq", bad, 0);
        beats = v.wr ? w_beats : rd_beats;
        obeats = v.wr ? rd_beats : w_beats;
        chk("beats", beats, nb);
        chk("other_beats", obeats, 0);
        chk("wdata", wdata_err, 0);
        chk("rd_latency", lat_err, 0);
        chk("addr_stable", stab_err, 0);
        chk("rd_err_done", err_at_done, ee);
        if (use_tab) begin
            first = na > 0 ? (v.wr ? aw_q[0] : ar_q[0]) : 'x;
            last = na > 0 ? (v.wr ? aw_q[na-1] : ar_q[na-1]) : 'x;
            chk("tab_first", first, v.ef);
            chk("tab_last", last, v.el);
            chk("tab_beats", beats, v.eb);
            chk("tab_err", err_at_done, v.ee);
        end
        tick();
    endtask

    // controller and FWFT source responder with channel monitors
    initial forever begin
        @(negedge clk);
        if (req_l) src_idx++;
        if (rd_data_valid !== prev_rv || (prev_rv && rd_data !== prev_rd)) lat_err++;
        if (rd_data_valid) rd_beats++;
        if (cmd_done) begin
            done_cnt++;
            busy_at_done = busy;
            err_at_done = rd_err;
        end
        if (ar_hs) begin
            r_rem = rlast_at < 16 ? rlast_at + 1 : 16;
            ar_hs = 0;
        end
        if (axi_awvalid) begin
            if (aw_cnt == 0) aw_hold = axi_awaddr;
            else if (axi_awaddr !== aw_hold) stab_err++;
            aw_cnt++;
            valid_cycles++;
        end else aw_cnt = 0;
        axi_awready = axi_awvalid && aw_cnt > aw_dly;
        if (axi_awvalid && axi_awready) aw_q.push_back(axi_awaddr);
        if (axi_arvalid) begin
            if (ar_cnt == 0) ar_hold = axi_araddr;
            else if (axi_araddr !== ar_hold) stab_err++;
            ar_cnt++;
            valid_cycles++;
        end else ar_cnt = 0;
        axi_arready = axi_arvalid && ar_cnt > aw_dly;
        if (axi_arvalid && axi_arready) begin
            ar_q.push_back(axi_araddr);
            ar_hs = 1;
        end
        axi_rdata = rnd256();
        if (r_rem > 0 && (rgap == 0 || $urandom_range(0, 2) != 0)) begin
            axi_rvalid = 1'b1;
            axi_rlast = r_rem == 1 && rlast_at < 16;
            r_rem--;
        end else begin
            axi_rvalid = 1'b0;
            axi_rlast = 1'b0;
        end
        prev_rv = axi_rvalid;
        prev_rd = axi_rdata;
        axi_wusero_last = 1'($urandom_range(0, 1));
        axi_wready = wmode == 0 ? 1'b1 : wmode == 1 ? ~axi_wready : 1'($urandom_range(0, 1));
        wr_data = src_idx < src_q.size() ? src_q[src_idx] : '0;
        #1;
        req_l = wr_data_req;
        if (req_l) begin
            w_beats++;
            if (axi_wdata !== wr_data) wdata_err++;
        end
    end

    // hang guard
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // directed sequences, vector table and randomized commands
    initial begin
        vec_t v;
        int t, r;
        rst = 1'b1;
        ddr_init_done = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr = 1'b0;
        cmd_addr = '0;
        cmd_burst_num = '0;
        tab[0] = '{1'b1, 28'h0000100, 2, 0, 0, 0, 15, 28'h0000100, 28'h0000180, 32, 1'b0};
        tab[1] = '{1'b1, 28'h0002000, 1, 5, 1, 0, 15, 28'h0002000, 28'h0002000, 16, 1'b0};
        tab[2] = '{1'b0, 28'hFFFFF80, 2, 0, 0, 1, 15, 28'hFFFFF80, 28'h0000000, 32, 1'b0};
        tab[3] = '{1'b0, 28'h0000040, 1, 0, 0, 0, 10, 28'h0000040, 28'h0000040, 11, 1'b1};
        tab[4] = '{1'b0, 28'h0000080, 1, 0, 0, 1, 20, 28'h0000080, 28'h0000080, 16, 1'b1};
        tab[5] = '{1'b1, 28'hFFFFF00, 3, 2, 2, 0, 15, 28'hFFFFF00, 28'h0000000, 48, 1'b0};
        tab[6] = '{1'b0, 28'h0001000, 3, 1, 0, 1, 15, 28'h0001000, 28'h0001100, 48, 1'b0};
        repeat (3) tick();
        check_reset("rst");
        rst = 1'b0;
        tick();

        clear_mon();
        ddr_init_done = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr = 1'b1;
        cmd_addr = 28'h0000123;
        cmd_burst_num = 8'd0;
        repeat (4) tick();
        chk("no_init_ready", cmd_ready, 0);
        chk("no_init_busy", busy, 0);
        ddr_init_done = 1'b1;
        #1;
        chk("init_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("zero_busy", busy, 1);
        chk("zero_done_early", cmd_done, 0);
        tick();
        chk("zero_done", cmd_done, 1);
        chk("zero_done_busy", busy, 0);
        chk("zero_done_ready", cmd_ready, 0);
        tick();
        chk("zero_done_end", cmd_done, 0);
        chk("zero_next_ready", cmd_ready, 1);
        chk("zero_no_axi", valid_cycles, 0);
        chk("zero_done_cnt", done_cnt, 1);

        wmode = 0;
        aw_dly = 0;
        src_q.delete();
        for (int i = 0; i < 40; i++) src_q.push_back(rnd256());
        clear_mon();
        cmd_wr = 1'b1;
        cmd_addr = 28'h0000400;
        cmd_burst_num = 8'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        t = 0;
        while (w_beats < 5 && t < 200) begin
            tick();
            t++;
        end
        chk("midrst_reached", w_beats >= 5, 1);
        chk("midrst_req", wr_data_req, 1);
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        repeat (5) tick();
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);

        for (int i = 0; i < 7; i++) run_cmd(tab[i], 1'b1);

        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 3);
            v.wr = 1'($urandom_range(0, 1));
            v.addr = 28'($urandom);
            v.n = $urandom_range(0, 3);
            v.dly = $urandom_range(0, 3);
            v.wm = $urandom_range(0, 2);
            v.rg = $urandom_range(0, 1);
            v.rl = r == 0 ? $urandom_range(0, 15) : r == 1 ? 20 : 15;
            v.ef = '0;
            v.el = '0;
            v.eb = 0;
            v.ee = 1'b0;
            run_cmd(v, 1'b0);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
